axis_s2mm_pkt_gen: RTL and testbench

AXI4-Stream packet source that feeds the AXI DMA S2MM slave port in the PL test designs.
- Replaces ad-hoc counter logic with a handshake-compliant generator:
  - tdata, tvalid and tlast are held stable while stalled.
  - tlast marks the last beat of each packet.
  - Packet length and payload pattern are set at runtime.
- Enabled by a PS GPIO bit.
- Exposes status (busy, packet count) for readback over GPIO.

---
 rtl/pkt_gen_pkg.sv | 26 ++
 rtl/lfsr32_galois.sv | 31 +++
 rtl/axis_s2mm_pkt_gen.sv | 156 +++++++++++++++
 tb/tb_axis_s2mm_pkt_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pkt_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pkt_gen_pkg : shared types and constants for the S2MM packet source  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package pkt_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'hFFFF_FFFF;

  localparam logic PAT_COUNTER = 1'b0;
  localparam logic PAT_LFSR    = 1'b1;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr32_galois.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr32_galois : 32-bit Galois LFSR, loads load_val on reset          |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module lfsr32_galois
  import pkt_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [31:0] load_val,
  output logic [31:0] q
);

  logic [31:0] q_q;
  logic [31:0] q_d;

  always_comb begin
    q_d = step ? lfsr_next(q_q) : q_q;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= load_val;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/axis_s2mm_pkt_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_s2mm_pkt_gen : AXI4-Stream packet source for the DMA S2MM port  |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module axis_s2mm_pkt_gen
  import pkt_gen_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          LEN_WIDTH  = 16,
  parameter int          GAP_CYCLES = 0,
  parameter logic [31:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic                    FCLK_CLK0,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    pattern_sel,
  input  logic [LEN_WIDTH-1:0]    pkt_len,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic [31:0]             pkt_count
);

  localparam logic [31:0] GAP_LAST = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q, tlast_d;
  logic [31:0]             pkt_count_q, pkt_count_d;
  logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    beat_q, beat_d;
  logic                    mode_q, mode_d;
  logic [31:0]             gap_q, gap_d;

  logic                    xfer;
  logic                    start;
  logic                    lfsr_step;
  logic [31:0]             lfsr_q;
  logic [31:0]             lfsr_after;
  logic [LEN_WIDTH-1:0]    len_c;

  lfsr32_galois u_lfsr (
    .clk      (FCLK_CLK0),
    .rst      (rst),
    .step     (lfsr_step),
    .load_val (LFSR_SEED),
    .q        (lfsr_q)
  );

  always_comb begin
    xfer       = tvalid_q & m_axis_tready;
    lfsr_step  = xfer & (mode_q == PAT_LFSR);
    lfsr_after = lfsr_step ? lfsr_next(lfsr_q) : lfsr_q;
    // Pattern sources are advanced first so a new packet starts from post-transfer values
    cnt_d      = (xfer && (mode_q == PAT_COUNTER)) ? cnt_q + DATA_WIDTH'(1) : cnt_q;
    len_c      = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;

    start       = 1'b0;
    state_d     = state_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    pkt_count_d = pkt_count_q;
    len_d       = len_q;
    beat_d      = beat_q;
    mode_d      = mode_q;
    gap_d       = gap_q;

    case (state_q)
      ST_IDLE: begin
        if (en) start = 1'b1;
      end
      ST_SEND: begin
        if (xfer) begin
          if (tlast_q) begin
            pkt_count_d = pkt_count_q + 32'd1;
            tvalid_d    = 1'b0;
            tlast_d     = 1'b0;
            if (GAP_CYCLES > 0) begin
              state_d = ST_GAP;
              gap_d   = 32'd0;
            end else if (en) begin
              start = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            beat_d  = beat_q + LEN_WIDTH'(1);
            tlast_d = ((beat_q + LEN_WIDTH'(1)) == (len_q - LEN_WIDTH'(1)));
            tdata_d = (mode_q == PAT_LFSR) ? DATA_WIDTH'(lfsr_after) : cnt_d;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (en) start = 1'b1;
          else    state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d  = ST_SEND;
      len_d    = len_c;
      mode_d   = pattern_sel;
      beat_d   = '0;
      tvalid_d = 1'b1;
      tlast_d  = (len_c == LEN_WIDTH'(1));
      tdata_d  = (pattern_sel == PAT_LFSR) ? DATA_WIDTH'(lfsr_after) : cnt_d;
    end
  end

  always_ff @(posedge FCLK_CLK0) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      pkt_count_q <= 32'd0;
      cnt_q       <= '0;
      len_q       <= LEN_WIDTH'(1);
      beat_q      <= '0;
      mode_q      <= PAT_COUNTER;
      gap_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      pkt_count_q <= pkt_count_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      mode_q      <= mode_d;
      gap_q       <= gap_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = '1;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = (state_q != ST_IDLE);
  assign pkt_count     = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_s2mm_pkt_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axis_s2mm_pkt_gen : directed self-checking bench                  |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module tb_axis_s2mm_pkt_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        pattern_sel = 1'b0;
  logic [15:0] pkt_len = 16'd4;
  logic        tready = 1'b1;

  logic [31:0] tdata,  g_tdata;
  logic [3:0]  tkeep,  g_tkeep;
  logic        tvalid, g_tvalid;
  logic        tlast,  g_tlast;
  logic        busy,   g_busy;
  logic [31:0] pcnt,   g_pcnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_s2mm_pkt_gen dut (
    .FCLK_CLK0(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .pkt_len(pkt_len),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid),
    .m_axis_tlast(tlast), .m_axis_tready(tready), .busy(busy), .pkt_count(pcnt)
  );

  axis_s2mm_pkt_gen #(.GAP_CYCLES(2)) dut_gap (
    .FCLK_CLK0(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .pkt_len(pkt_len),
    .m_axis_tdata(g_tdata), .m_axis_tkeep(g_tkeep), .m_axis_tvalid(g_tvalid),
    .m_axis_tlast(g_tlast), .m_axis_tready(tready), .busy(g_busy), .pkt_count(g_pcnt)
  );

  // Reference LFSR: toggle taps for x^22, x^2, x^1 and feed back into bit 31.
  function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[31] = 1'b1;
      n[21] = ~n[21];
      n[1]  = ~n[1];
      n[0]  = ~n[0];
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; pattern_sel = 1'b0; pkt_len = 16'd4; tready = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", tvalid); end
    checks++; if (tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", tlast); end
    checks++; if (tdata !== 32'd0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", tdata); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (pcnt !== 32'd0) begin failures++; $display("FAIL reset_pkt_count got=%0d exp=0", pcnt); end
    checks++; if (tkeep !== 4'hF) begin failures++; $display("FAIL reset_tkeep got=%h exp=f", tkeep); end
  endtask

  task automatic test_counter();
    do_reset();
    en = 1'b1;
    checks++; if (tvalid !== 1'b0) begin failures++; $display("FAIL cnt_tvalid_latency got=%b exp=0", tvalid); end
    step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'(i) || tlast !== (i % 4 == 3) || busy !== 1'b1) begin
        failures++;
        $display("FAIL cnt_beat%0d got v=%b d=%0d l=%b b=%b exp v=1 d=%0d l=%b b=1",
                 i, tvalid, tdata, tlast, busy, i, (i % 4 == 3));
      end
      step();
    end
    checks++; if (pcnt !== 32'd2) begin failures++; $display("FAIL cnt_pkt_count got=%0d exp=2", pcnt); end
  endtask

  task automatic test_stall();
    do_reset();
    en = 1'b1;
    step(); step(); step();
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'd2 || tlast !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d got v=%b d=%0d l=%b exp v=1 d=2 l=0", i, tvalid, tdata, tlast);
      end
    end
    tready = 1'b1;
    step();
    checks++; if (tdata !== 32'd3 || tlast !== 1'b1) begin failures++; $display("FAIL stall_beat3 got d=%0d l=%b exp d=3 l=1", tdata, tlast); end
    step();
    checks++; if (tdata !== 32'd4 || tlast !== 1'b0 || pcnt !== 32'd1) begin failures++; $display("FAIL stall_beat4 got d=%0d l=%b c=%0d exp d=4 l=0 c=1", tdata, tlast, pcnt); end
  endtask

  task automatic test_len_change();
    do_reset();
    en = 1'b1; pkt_len = 16'd0;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'(i) || tlast !== 1'b1 || pcnt !== 32'(i)) begin
        failures++;
        $display("FAIL len0_beat%0d got d=%0d l=%b c=%0d exp d=%0d l=1 c=%0d", i, tdata, tlast, pcnt, i, i);
      end
      step();
    end
    checks++; if (pcnt !== 32'd3) begin failures++; $display("FAIL len0_pkt_count got=%0d exp=3", pcnt); end
    pkt_len = 16'd4;
    step();
    checks++; if (tdata !== 32'd4 || tlast !== 1'b0) begin failures++; $display("FAIL len4_beat0 got d=%0d l=%b exp d=4 l=0", tdata, tlast); end
    pkt_len = 16'd5;
    step();
    for (int j = 1; j < 4; j++) begin
      checks++;
      if (tdata !== 32'(4 + j) || tlast !== (j == 3)) begin
        failures++;
        $display("FAIL len4_beat%0d got d=%0d l=%b exp d=%0d l=%b", j, tdata, tlast, 4 + j, (j == 3));
      end
      step();
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (tdata !== 32'(8 + k) || tlast !== (k == 4)) begin
        failures++;
        $display("FAIL len5_beat%0d got d=%0d l=%b exp d=%0d l=%b", k, tdata, tlast, 8 + k, (k == 4));
      end
      step();
    end
  endtask

  task automatic test_en_drop();
    do_reset();
    en = 1'b1; pkt_len = 16'd128;
    step(); step();
    en = 1'b0;
    for (int i = 1; i < 128; i++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'(i) || tlast !== (i == 127)) begin
        failures++;
        $display("FAIL endrop_beat%0d got v=%b d=%0d l=%b exp v=1 d=%0d l=%b", i, tvalid, tdata, tlast, i, (i == 127));
      end
      step();
    end
    checks++; if (tvalid !== 1'b0 || busy !== 1'b0 || pcnt !== 32'd1) begin failures++; $display("FAIL endrop_idle got v=%b b=%b c=%0d exp v=0 b=0 c=1", tvalid, busy, pcnt); end
    step();
    checks++; if (tvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL endrop_stay_idle got v=%b b=%b exp v=0 b=0", tvalid, busy); end
  endtask

  task automatic test_lfsr_gap();
    logic [31:0] exp_w;
    do_reset();
    en = 1'b1; pattern_sel = 1'b1; pkt_len = 16'd3;
    step();
    exp_w = 32'hFFFF_FFFF;
    checks++; if (tdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL lfsr_seed got=%h exp=ffffffff", tdata); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tdata !== exp_w || tlast !== (i == 2) || g_tdata !== exp_w || g_tlast !== (i == 2) || g_tvalid !== 1'b1) begin
        failures++;
        $display("FAIL lfsr_word%0d got d=%h l=%b gd=%h gl=%b gv=%b exp d=%h l=%b", i, tdata, tlast, g_tdata, g_tlast, g_tvalid, exp_w, (i == 2));
      end
      exp_w = ref_lfsr(exp_w);
      step();
    end
    checks++; if (tvalid !== 1'b1 || tdata !== exp_w || tdata !== 32'h3FF7_FFFF) begin failures++; $display("FAIL lfsr_b2b got v=%b d=%h exp v=1 d=%h", tvalid, tdata, exp_w); end
    checks++; if (g_tvalid !== 1'b0 || g_busy !== 1'b1) begin failures++; $display("FAIL gap_cycle0 got v=%b b=%b exp v=0 b=1", g_tvalid, g_busy); end
    step();
    checks++; if (g_tvalid !== 1'b0 || g_busy !== 1'b1) begin failures++; $display("FAIL gap_cycle1 got v=%b b=%b exp v=0 b=1", g_tvalid, g_busy); end
    step();
    checks++; if (g_tvalid !== 1'b1 || g_tdata !== exp_w || g_tlast !== 1'b0 || g_pcnt !== 32'd1) begin failures++; $display("FAIL gap_resume got v=%b d=%h l=%b c=%0d exp v=1 d=%h l=0 c=1", g_tvalid, g_tdata, g_tlast, g_pcnt, exp_w); end
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 6; i++) step();
    tready = 1'b0;
    checks++; if (tdata !== 32'd5 || pcnt !== 32'd1) begin failures++; $display("FAIL midrst_pre got d=%0d c=%0d exp d=5 c=1", tdata, pcnt); end
    rst = 1'b1;
    step();
    checks++; if (tvalid !== 1'b0 || tlast !== 1'b0 || pcnt !== 32'd0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_state got v=%b l=%b c=%0d b=%b exp v=0 l=0 c=0 b=0", tvalid, tlast, pcnt, busy); end
    rst = 1'b0; tready = 1'b1;
    step();
    checks++; if (tvalid !== 1'b1 || tdata !== 32'd0) begin failures++; $display("FAIL midrst_restart got v=%b d=%0d exp v=1 d=0", tvalid, tdata); end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_stall();
    test_len_change();
    test_en_drop();
    test_lfsr_gap();
    test_reset_midpacket();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
